// File: rtl/instr_fetch_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_pkg
// Shared definitions for the fetch stage:
//   SequencerState : CPU sequencer state encoding (4-bit; encodings 10..15
//                    are unused and are treated like SRST by the fetch stage)
//   OP_*           : opcode constants decoded from instr[31:28]
//   INSTR_W        : instruction width in bits
//   NUM_BYTES      : number of bytes in one instruction word
//   op_is_illegal  : opcode range check for the illegal set
// ---------------------------------------------------------------------------
package instr_fetch_pkg;

  typedef enum logic [3:0] {
    SRST    = 4'd0,
    SR1     = 4'd1,
    SR2     = 4'd2,
    SR3     = 4'd3,
    SR4     = 4'd4,
    SCALC   = 4'd5,
    SWRITE  = 4'd6,
    SNXT    = 4'd7,
    SFINISH = 4'd8,
    SERR    = 4'd9
  } SequencerState;

  localparam logic [3:0] OP_HALT   = 4'hF;
  localparam logic [3:0] OP_ILL_LO = 4'hC;
  localparam logic [3:0] OP_ILL_HI = 4'hE;

  localparam int INSTR_W   = 32;
  localparam int NUM_BYTES = INSTR_W / 8;

  function automatic logic op_is_illegal(input logic [3:0] op);
    return (op >= OP_ILL_LO) && (op <= OP_ILL_HI);
  endfunction

endpackage

// File: rtl/instr_fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_pc_unit
// Program counter owner for the fetch stage. Captures a jump request in
// SWRITE, applies it (or a sequential increment) in SNXT, and flags an
// out-of-range jump or running off the end of program memory.
// Ports:
//   clk, rstn    : clock (rising edge), asynchronous active-low reset
//   seq_q        : current sequencer state
//   jmp_en       : jump request, sampled in SWRITE
//   jmp_target   : jump destination word index, sampled in SWRITE
//   pc           : current instruction word index (registered)
//   pc_err       : combinational fault flag, only ever high in SNXT
// ---------------------------------------------------------------------------
module instr_fetch_pc_unit
  import instr_fetch_pkg::*;
#(
  parameter int PC_W       = 8,
  parameter int PROG_DEPTH = 256
) (
  input  logic            clk,
  input  logic            rstn,
  input  SequencerState   seq_q,
  input  logic            jmp_en,
  input  logic [PC_W-1:0] jmp_target,
  output logic [PC_W-1:0] pc,
  output logic            pc_err
);

  // One extra bit so PROG_DEPTH == 2**PC_W is representable.
  localparam logic [PC_W:0]   DEPTH_EXT = (PC_W+1)'(PROG_DEPTH);
  localparam logic [PC_W-1:0] LAST_PC   = PC_W'(PROG_DEPTH - 1);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_jmp_addr;
  logic            r_jmp_pend;

  logic            w_jmp_ok;
  logic            w_at_end;
  logic            w_pc_err;
  logic [PC_W-1:0] w_pc_next;

  assign w_jmp_ok  = ({1'b0, r_jmp_addr} < DEPTH_EXT);
  assign w_at_end  = (r_pc == LAST_PC);
  // A pending jump takes priority over the end-of-program check: a valid
  // jump from the last word is legal.
  assign w_pc_err  = (seq_q == SNXT) && (r_jmp_pend ? !w_jmp_ok : w_at_end);
  assign w_pc_next = r_jmp_pend ? r_jmp_addr : r_pc + 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc       <= '0;
      r_jmp_pend <= 1'b0;
      r_jmp_addr <= '0;
    end else begin
      case (seq_q)
        SR1, SR2, SR3, SR4, SCALC, SFINISH, SERR: begin
          // hold
        end
        SWRITE: begin
          r_jmp_pend <= jmp_en;
          r_jmp_addr <= jmp_target;
        end
        SNXT: begin
          // On a fault pc holds so the sequencer can report where it stopped.
          if (!w_pc_err) begin
            r_pc <= w_pc_next;
          end
          r_jmp_pend <= 1'b0;
        end
        default: begin
          // SRST and unused encodings: restart from word 0.
          r_pc       <= '0;
          r_jmp_pend <= 1'b0;
        end
      endcase
    end
  end

  assign pc     = r_pc;
  assign pc_err = w_pc_err;

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Fetch stage driven by the CPU sequencer. Reads four bytes of program
// memory during SR1..SR4 and assembles them big-endian into instr, which is
// complete on the first SCALC cycle. Decodes HALT / illegal opcodes and
// merges the pc_unit fault into the sequencer's finish / err inputs.
// Ports:
//   clk, rstn    : clock (rising edge), asynchronous active-low reset
//   seq_q        : current sequencer state
//   mem_addr     : byte address {pc, byte_idx}
//   mem_rd       : read strobe, high in SR1..SR4
//   mem_rdata    : byte returned combinationally for mem_addr
//   jmp_en       : jump request, sampled in SWRITE
//   jmp_target   : jump destination word index, sampled in SWRITE
//   instr        : assembled instruction (registered)
//   pc           : current instruction word index (registered)
//   finish       : HALT opcode seen in SCALC (combinational)
//   err          : illegal opcode in SCALC or pc fault in SNXT (comb.)
// ---------------------------------------------------------------------------
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int PC_W       = 8,
  parameter int PROG_DEPTH = 256,
  parameter int ADDR_W     = PC_W + 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  SequencerState      seq_q,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  input  logic [7:0]         mem_rdata,
  input  logic               jmp_en,
  input  logic [PC_W-1:0]    jmp_target,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc,
  output logic               finish,
  output logic               err
);

  if (PROG_DEPTH < 1 || longint'(PROG_DEPTH) > (longint'(1) << PC_W)) begin : g_bad_depth
    $error("instr_fetch: PROG_DEPTH must be in 1..2**PC_W");
  end
  if (ADDR_W != PC_W + 2) begin : g_bad_addr_w
    $error("instr_fetch: ADDR_W is derived and must equal PC_W+2");
  end

  logic       w_fetch;
  logic [1:0] w_byte_idx;
  logic       w_calc;
  logic       w_clear;
  logic       w_pc_err;
  logic [3:0] w_opcode;
  logic [PC_W-1:0] w_pc;

  // State decode. Unused encodings fall into the SRST behaviour.
  always_comb begin
    w_fetch    = 1'b0;
    w_byte_idx = 2'd0;
    w_calc     = 1'b0;
    w_clear    = 1'b0;
    case (seq_q)
      SR1:     begin w_fetch = 1'b1; w_byte_idx = 2'd0; end
      SR2:     begin w_fetch = 1'b1; w_byte_idx = 2'd1; end
      SR3:     begin w_fetch = 1'b1; w_byte_idx = 2'd2; end
      SR4:     begin w_fetch = 1'b1; w_byte_idx = 2'd3; end
      SCALC:   w_calc = 1'b1;
      SWRITE, SNXT, SFINISH, SERR: begin
        // no fetch-side activity
      end
      default: w_clear = 1'b1;
    endcase
  end

  instr_fetch_pc_unit #(
    .PC_W       (PC_W),
    .PROG_DEPTH (PROG_DEPTH)
  ) u_pc_unit (
    .clk        (clk),
    .rstn       (rstn),
    .seq_q      (seq_q),
    .jmp_en     (jmp_en),
    .jmp_target (jmp_target),
    .pc         (w_pc),
    .pc_err     (w_pc_err)
  );

  // One register per byte lane; lane 0 is the most significant byte and is
  // loaded in SR1, so the word lands big-endian.
  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
    logic [7:0] r_byte;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_byte <= 8'h00;
      end else if (w_clear) begin
        r_byte <= 8'h00;
      end else if (w_fetch && (w_byte_idx == 2'(gi))) begin
        r_byte <= mem_rdata;
      end
    end

    assign instr[INSTR_W-1-8*gi -: 8] = r_byte;
  end

  assign w_opcode = instr[INSTR_W-1 -: 4];
  assign pc       = w_pc;
  assign mem_addr = {w_pc, w_byte_idx};

  // rstn gates the strobes so they are quiet during reset regardless of
  // what the sequencer is driving.
  assign mem_rd = rstn && w_fetch;
  assign finish = rstn && w_calc && (w_opcode == OP_HALT);
  assign err    = rstn && ((w_calc && op_is_illegal(w_opcode)) || w_pc_err);

endmodule
